// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants, beat type and round-robin grant helper for stream_mux_n
`timescale 1ns/1ps
package stream_mux_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_CH_DEF   = 4;
    localparam int SEL_W_DEF  = $clog2(N_CH_DEF);
    localparam int MAX_CH     = 64;

    typedef struct packed {
        logic [SEL_W_DEF-1:0]  chan;
        logic [DATA_W_DEF-1:0] data;
    } beat_t;

    // First valid channel found walking from ptr+1 with wrap; -1 when none is valid.
    function automatic int next_rr_grant(input logic [MAX_CH-1:0] valid,
                                         input int ptr,
                                         input int n_ch);
        int idx;
        next_rr_grant = -1;
        for (int k = n_ch; k >= 1; k--) begin
            idx = (ptr + k) % n_ch;
            if (valid[idx]) begin
                next_rr_grant = idx;
            end
        end
    endfunction

endpackage

// File: rtl/stream_mux_n_skid.sv
// rtl/stream_mux_n_skid.sv - pipe_skid_reg: registered output stage with a one-entry skid buffer
`timescale 1ns/1ps
module pipe_skid_reg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] skid_data;
    logic         skid_full;
    logic         accept;
    logic         pop;

    // Ready comes straight from the skid flag, so out_ready never reaches in_ready.
    assign in_ready = ~skid_full;
    assign accept   = in_valid & ~skid_full;
    assign pop      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            skid_data <= '0;
            skid_full <= 1'b0;
        end else if (skid_full) begin
            // A full skid implies main is occupied; drain it on the next pop.
            if (out_ready) begin
                out_data  <= skid_data;
                skid_full <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_data <= in_data;
                skid_full <= 1'b1;
            end
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-channel registered stream mux; round-robin arbitration under STREAM_MUX_RR_EN
`timescale 1ns/1ps
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int N_CH   = N_CH_DEF,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]       sel,
`ifdef STREAM_MUX_RR_EN
    input  logic                   arb_mode,
`endif
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic                    grant_ok;
    logic [SEL_W-1:0]        grant_idx;
    logic [DATA_W-1:0]       grant_data;
    logic                    stage_valid;
    logic                    stage_ready;
    logic [SEL_W+DATA_W-1:0] stage_out;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;
    int               rr_grant;

    always_comb begin
        rr_grant = next_rr_grant(MAX_CH'(in_valid), int'(rr_ptr), N_CH);
    end
`endif

    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
`ifdef STREAM_MUX_RR_EN
        if (arb_mode) begin
            if (rr_grant >= 0) begin
                grant_ok  = 1'b1;
                grant_idx = SEL_W'(rr_grant);
            end
        end else
`endif
        // Out-of-range select grants nothing rather than aliasing a channel.
        if (int'(sel) < N_CH) begin
            grant_ok  = 1'b1;
            grant_idx = sel;
        end
    end

    always_comb begin
        grant_data = in_data[grant_idx*DATA_W +: DATA_W];
    end

    assign stage_valid = grant_ok & in_valid[grant_idx];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = rst_n & stage_ready & grant_ok & (grant_idx == SEL_W'(i));
        end
    end

`ifdef STREAM_MUX_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SEL_W'(N_CH - 1);
        end else if (arb_mode && stage_valid && stage_ready) begin
            rr_ptr <= grant_idx;
        end
    end
`endif

    pipe_skid_reg #(
        .W(SEL_W + DATA_W)
    ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  ({grant_idx, grant_data}),
        .in_valid (stage_valid),
        .in_ready (stage_ready),
        .out_data (stage_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign {out_chan, out_data} = stage_out;

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - directed scoreboard bench for stream_mux_n (RR steps need STREAM_MUX_RR_EN)
`timescale 1ns/1ps
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int NC = N_CH_DEF;
    localparam int SW = SEL_W_DEF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]    in_valid;
    logic [NC-1:0]    in_ready;
    logic [SW-1:0]    sel;
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready;

    logic [5*DW-1:0]  in_data5;
    logic [4:0]       in_valid5;
    logic [4:0]       in_ready5;
    logic [2:0]       sel5;
    logic [DW-1:0]    out_data5;
    logic [2:0]       out_chan5;
    logic             out_valid5;
    logic             out_ready5;

`ifdef STREAM_MUX_RR_EN
    logic arb_mode = 1'b0;
    logic arb_mode5 = 1'b0;
`endif

    int        n_checks = 0;
    int        n_pass = 0;
    int        rx_count = 0;
    beat_t     sb[$];
    int        chan_log[$];
    bit        orp [0:11] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    always #5 clk = ~clk;

    stream_mux_n #(.DATA_W(DW), .N_CH(NC)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
`ifdef STREAM_MUX_RR_EN
        .arb_mode (arb_mode),
`endif
        .out_data (out_data),
        .out_chan (out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_n #(.DATA_W(DW), .N_CH(5)) u_dut5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data5),
        .in_valid (in_valid5),
        .in_ready (in_ready5),
        .sel      (sel5),
`ifdef STREAM_MUX_RR_EN
        .arb_mode (arb_mode5),
`endif
        .out_data (out_data5),
        .out_chan (out_chan5),
        .out_valid(out_valid5),
        .out_ready(out_ready5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] d);
        in_data[ch*DW +: DW] = d;
    endtask

    task automatic drain(input string tag, input int exp_n);
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_drained"}, 64'(sb.size() == 0 && !out_valid), 64'd1);
        chk({tag, "_count"}, 64'(rx_count), 64'(exp_n));
    endtask

    // Scoreboard: pop on output handshake, push on input handshake.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'({out_chan, out_data}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_beat", 64'({out_chan, out_data}), 64'(e));
                    rx_count++;
                    chan_log.push_back(int'(out_chan));
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    e.chan = SW'(i);
                    e.data = in_data[i*DW +: DW];
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        int idx;
        in_data    = '0;
        in_valid   = '0;
        sel        = '0;
        out_ready  = 1'b1;
        in_data5   = '0;
        in_valid5  = '0;
        sel5       = '0;
        out_ready5 = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Fixed select, continuous stream on channel 2.
        sel = 2'd2;
        rx_count = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            in_valid = 4'b0100;
            set_ch(2, 32'hA5A5_0001 + k);
            @(negedge clk);
            chk("t2_in_ready", 64'(in_ready), 64'b0100);
            if (k > 0) begin
                chk("t2_lat_valid", 64'(out_valid), 64'd1);
                chk("t2_lat_data", 64'(out_data), 64'(32'hA5A5_0001 + k - 1));
                chk("t2_chan", 64'(out_chan), 64'd2);
            end
        end
        @(posedge clk); #1 in_valid = '0;
        @(negedge clk);
        chk("t2_last_data", 64'(out_data), 64'h0A5A5_0008);
        drain("t2", 8);

        // Backpressure: three stalled cycles push one beat into the skid.
        idx = 0;
        rx_count = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            out_ready = orp[c];
            in_valid  = (idx < 6) ? 4'b0100 : 4'b0000;
            set_ch(2, 32'hB000_0000 + idx);
            @(negedge clk);
            if (c == 1) chk("t3_rdy_before_skid", 64'(in_ready), 64'b0100);
            if (c == 2 || c == 3) begin
                chk("t3_rdy_skid_full", 64'(in_ready), 64'd0);
                chk("t3_data_held", 64'(out_data), 64'hB000_0000);
                chk("t3_valid_held", 64'(out_valid), 64'd1);
            end
            if (c == 4) chk("t3_rdy_release", 64'(in_ready), 64'd0);
            if (in_valid[2] && in_ready[2]) idx++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = '0;
        drain("t3", 6);

        // Out-of-range select on a 5-channel instance.
        sel5      = 3'd5;
        in_valid5 = '1;
        for (int k = 0; k < 5; k++) in_data5[k*DW +: DW] = 32'h5500_0000 + k;
        repeat (3) begin
            @(negedge clk);
            chk("t4_in_ready", 64'(in_ready5), 64'd0);
            chk("t4_out_valid", 64'(out_valid5), 64'd0);
        end
        in_valid5 = '0;

        // Asynchronous reset in the middle of a stream.
        rx_count = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 4'b0100;
            set_ch(2, 32'hE000_0000 + k);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_out_data", 64'(out_data), 64'd0);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        in_valid = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef STREAM_MUX_RR_EN
        begin
            logic [3:0] exp5 [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            logic [3:0] exp6 [0:5] = '{4'b0001, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000};
            bit         or6  [0:5] = '{1, 0, 1, 0, 1, 0};
            int         ch5  [0:4] = '{0, 1, 2, 3, 0};
            int         ch6  [0:3] = '{0, 3, 0, 3};

            // Round-robin with every channel valid.
            rx_count = 0;
            chan_log.delete();
            arb_mode  = 1'b1;
            out_ready = 1'b1;
            for (int i = 0; i < NC; i++) set_ch(i, 32'hC000_0000 + i);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1 in_valid = 4'b1111;
                @(negedge clk);
                chk("t5_grant", 64'(in_ready), 64'(exp5[c]));
            end
            @(posedge clk); #1 in_valid = '0;
            drain("t5", 5);
            chk("t5_log_size", 64'(chan_log.size()), 64'd5);
            for (int i = 0; i < chan_log.size() && i < 5; i++)
                chk("t5_chan_order", 64'(chan_log[i]), 64'(ch5[i]));

            // Reset pointer, then two channels under alternating backpressure.
            @(posedge clk); #1 rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
            rx_count = 0;
            chan_log.delete();
            set_ch(0, 32'hD000_0000);
            set_ch(3, 32'hD000_0003);
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                in_valid  = 4'b1001;
                out_ready = or6[c];
                @(negedge clk);
                chk("t6_grant", 64'(in_ready), 64'(exp6[c]));
            end
            @(posedge clk); #1;
            in_valid  = '0;
            out_ready = 1'b1;
            drain("t6", 4);
            chk("t6_log_size", 64'(chan_log.size()), 64'd4);
            for (int i = 0; i < chan_log.size() && i < 4; i++)
                chk("t6_chan_order", 64'(chan_log[i]), 64'(ch6[i]));
            arb_mode = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
